armleocpu_divider: RTL and testbench

//  Iterative restoring divider, the inverse of armleocpu_multiplier: takes a

---
 rtl/armleocpu_divider.sv | 159 +++++++++++++++
 tb/tb_armleocpu_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_divider.sv
// armleocpu_divider: iterative restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle. Divide-by-zero skips the iteration entirely.
// The output registers load on the DONE edge, and ready is a registered
// one-cycle pulse that follows it.
// Optional feature macro: DIVIDER_SIGNED_EN. It enables signed operation
// through is_signed: operands are made absolute at accept and the signs are
// fixed up in one extra cycle. Without the macro, is_signed is ignored.
module armleocpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             ready,
  output logic             division_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;      // partial remainder
  logic [WIDTH-1:0] dvd_reg;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg;
  logic             dbz_op_reg;   // current op is a divide-by-zero
  logic             signed_reg;   // current op needs the sign fixup cycle
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;
  logic             ready_reg;

  logic             div_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign div_zero = (divisor == '0);

`ifdef DIVIDER_SIGNED_EN
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  // The most negative value maps to itself, which read as unsigned is its magnitude.
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor  : divisor;

  // One restoring step. The borrow out of the widened subtraction is the compare.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             unused_diff_bit;

  assign shifted         = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff            = {1'b0, shifted} - {2'b00, dvs_reg};
  assign ge              = ~diff[WIDTH+1];
  assign rem_step        = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step        = {dvd_reg[WIDTH-2:0], ge};
  assign unused_diff_bit = diff[WIDTH];

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic. Valid is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (valid) state_next = div_zero ? DONE : CALC;
      CALC:  if (cnt_reg == '0) state_next = signed_reg ? FIXUP : DONE;
      FIXUP: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and the output registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      dbz_op_reg    <= 1'b0;
      signed_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: if (valid) begin
          dbz_reg    <= 1'b0;
          dbz_op_reg <= div_zero;
          cnt_reg    <= CW'(WIDTH - 1);
          rem_reg    <= '0;
          // A divide-by-zero hands back the untouched dividend as the remainder.
          dvd_reg    <= div_zero ? dividend : a_abs;
          dvs_reg    <= b_abs;
`ifdef DIVIDER_SIGNED_EN
          signed_reg <= is_signed;
`else
          signed_reg <= 1'b0;
`endif
          neg_q_reg  <= a_neg ^ b_neg;
          neg_r_reg  <= a_neg;
        end
        CALC: begin
          rem_reg <= rem_step;
          dvd_reg <= quo_step;
          cnt_reg <= cnt_reg - CW'(1);
        end
`ifdef DIVIDER_SIGNED_EN
        FIXUP: begin
          dvd_reg <= neg_q_reg ? -dvd_reg : dvd_reg;
          rem_reg <= neg_r_reg ? -rem_reg : rem_reg;
        end
`endif
        DONE: begin
          ready_reg <= 1'b1;
          if (dbz_op_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= dvd_reg;
            dbz_reg       <= 1'b1;
          end else begin
            quotient_reg  <= dvd_reg;
            remainder_reg <= rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready            = ready_reg;
  assign division_by_zero = dbz_reg;
  assign quotient         = quotient_reg;
  assign remainder        = remainder_reg;

endmodule

// File: tb/tb_armleocpu_divider.sv
// Scoreboard bench for armleocpu_divider: the driver pushes the expected result,
// computed with plain / and %, and the cycle of acceptance. A monitor pops
// and compares one entry whenever ready is seen.
module tb_armleocpu_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         division_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  armleocpu_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .dividend(dividend),
    .divisor(divisor), .is_signed(is_signed), .ready(ready),
    .division_by_zero(division_by_zero), .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           c0;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: RISC-V M-extension results plus the expected latency.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.dbz = 1'b0;
    e.c0  = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (s) begin
      e.lat = W + 2;
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        e.q = a; e.r = '0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end
`endif
    else begin
      e.q = a / b; e.r = a % b; e.lat = W + 1;
    end
    if (s === 1'bx) e.lat = -1;
    return e;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_ready: got ready=1, expected no pending op (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {{(W-1){1'b0}}, division_by_zero}, {{(W-1){1'b0}}, e.dbz});
        check("latency", W'(cyc - e.c0), W'(e.lat));
        $display("[TB] resp q=%h r=%h dbz=%0b lat=%0d", quotient, remainder, division_by_zero, cyc - e.c0);
        resp_cnt++;
      end
    end
  end

  // Issue one op; called in the low phase. glitch bit0: stray valid mid-CALC,
  // bit1: stray valid in the DONE cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int glitch);
    exp_t e;
    int target;
    int n;
    e = model(a, b, s);
    target = resp_cnt + 1;
    $display("[TB] op a=%h b=%h s=%0b glitch=%0d", a, b, s, glitch);
    dividend = a; divisor = b; is_signed = s; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    e.c0 = cyc;
    sb.push_back(e);
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    if ((glitch & 1) != 0 && e.lat > 8) begin
      repeat (4) @(negedge clk);
      dividend = $urandom; divisor = $urandom | 1; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
    end
    if ((glitch & 2) != 0) begin
      while (cyc < e.c0 + e.lat - 1) @(negedge clk);
      dividend = $urandom; divisor = $urandom; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
    end
    n = 0;
    while (resp_cnt < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (resp_cnt < target) begin
      fails++;
      $display("FAIL timeout: got no ready within %0d cycles, expected one", n);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, expected earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", {{(W-1){1'b0}}, ready}, '0);
    check("reset_dbz", {{(W-1){1'b0}}, division_by_zero}, '0);
    check("reset_q", quotient, '0);
    check("reset_r", remainder, '0);
    rst_n = 1'b0;
    @(negedge clk);

    do_op(32'd3392, 32'd53, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("hold_q", quotient, 32'd64);
    do_op(32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 0);
    do_op(32'd100, 32'd0, 1'b0, 0);
    do_op(32'd10, 32'd3, 1'b0, 0);
    do_op(32'd1000, 32'd7, 1'b0, 3);
    do_op(32'd5, 32'd0, 1'b0, 2);
    do_op(32'd5, 32'd9, 1'b0, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b0, 0);

    // Reset in the middle of an op: nothing pending, no ready may follow.
    $display("[TB] op a=12345678 b=00000013 interrupted by reset");
    dividend = 32'h1234_5678; divisor = 32'h13; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_mid_ready", {{(W-1){1'b0}}, ready}, '0);
    check("rst_mid_q", quotient, '0);
    check("rst_mid_r", remainder, '0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (40) @(negedge clk);
    do_op(32'd7, 32'd7, 1'b0, 0);

`ifdef DIVIDER_SIGNED_EN
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        3: begin a = a >> 1; b = a + W'($urandom_range(1, 100)); end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
